// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the serial subtractor: request side (start, a, b)
// and result side (busy, done, diff, flags).
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b, two bits per cycle through a borrow-ripple
// slice, with the borrow carried in a flop between slices.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | waiting for start; results hold the last computed value
//   S_RUN  | consuming two operand bits per cycle, busy=1
//   S_DONE | one-cycle done pulse; new result visible; may re-accept start
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH / 2) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             overflow_q, overflow_d;

    logic [2:0]       slice_sum;
    logic             slice_bo;
    logic [WIDTH-1:0] diff_next;
    logic             accept;

    always_comb begin
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        diff_sr_d    = diff_sr_q;
        borrow_d     = borrow_q;
        cnt_d        = cnt_q;
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        overflow_d   = overflow_q;

        // a - b as a + ~b + 1; the incoming borrow removes the +1
        slice_sum = {1'b0, a_sr_q[1:0]} + {1'b0, ~b_sr_q[1:0]} + {2'b00, ~borrow_q};
        slice_bo  = ~slice_sum[2];
        diff_next = (diff_sr_q >> 2) | (WIDTH'(slice_sum[1:0]) << (WIDTH - 2));

        // Start is honoured from IDLE and from DONE (back-to-back), never in RUN
        accept = (state_q != S_RUN) && bus.start;

        case (state_q)
            S_RUN: begin
                a_sr_d    = a_sr_q >> 2;
                b_sr_d    = b_sr_q >> 2;
                diff_sr_d = diff_next;
                borrow_d  = slice_bo;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d      = S_DONE;
                    diff_d       = diff_next;
                    borrow_out_d = slice_bo;
                    overflow_d   = (a_msb_q != b_msb_q) && (diff_next[WIDTH-1] != a_msb_q);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            state_d   = S_RUN;
            a_sr_d    = bus.a;
            b_sr_d    = bus.b;
            a_msb_d   = bus.a[WIDTH-1];
            b_msb_d   = bus.b[WIDTH-1];
            diff_sr_d = '0;
            borrow_d  = 1'b0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            diff_sr_q    <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            diff_sr_q    <= diff_sr_d;
            borrow_q     <= borrow_d;
            cnt_q        <= cnt_d;
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.busy       = (state_q == S_RUN);
    assign bus.done       = (state_q == S_DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): latency, arithmetic flags,
// start-while-busy, mid-operation reset and back-to-back operation.
module tb_serial_subtractor;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    serial_subtractor_if #(.WIDTH(8)) bus ();

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation from IDLE and wait (bounded) for done.
    // lat = cycles from the start edge to the done cycle, -1 on timeout.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         output int lat, output bit busy_ok);
        @(negedge clk);
        bus.start = 1'b1; bus.a = av; bus.b = bv;
        @(negedge clk);
        bus.start = 1'b0; bus.a = ~av; bus.b = ~bv;
        lat = -1;
        busy_ok = bus.busy;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i;
                if (bus.busy) busy_ok = 1'b0;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({bus.busy, bus.done, bus.diff, bus.borrow_out, bus.overflow} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b diff=%h bo=%b ov=%b, want all 0",
                     bus.busy, bus.done, bus.diff, bus.borrow_out, bus.overflow);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        bit bok;
        do_op(8'h5A, 8'h23, lat, bok);
        n_vec++;
        if (lat !== 4) begin n_err++; $display("FAIL basic_latency: got %0d want 4", lat); end
        n_vec++;
        if (bok !== 1'b1) begin n_err++; $display("FAIL basic_busy: busy profile wrong, got %b want 1", bok); end
        n_vec++;
        if ({bus.diff, bus.borrow_out, bus.overflow} !== {8'h37, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL basic_result: got diff=%h bo=%b ov=%b want 37 0 0",
                     bus.diff, bus.borrow_out, bus.overflow);
        end
        @(negedge clk);
        n_vec++;
        if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: got done=%b want 0", bus.done); end
        n_vec++;
        if (bus.diff !== 8'h37) begin n_err++; $display("FAIL result_hold: got %h want 37", bus.diff); end
    endtask

    task automatic test_borrow();
        int lat;
        bit bok;
        do_op(8'h10, 8'h20, lat, bok);
        n_vec++;
        if ({bus.diff, bus.borrow_out, bus.overflow} !== {8'hF0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL borrow_10_20: got diff=%h bo=%b ov=%b want f0 1 0",
                     bus.diff, bus.borrow_out, bus.overflow);
        end
        do_op(8'h00, 8'hFF, lat, bok);
        n_vec++;
        if ({bus.diff, bus.borrow_out} !== {8'h01, 1'b1}) begin
            n_err++;
            $display("FAIL borrow_00_ff: got diff=%h bo=%b want 01 1", bus.diff, bus.borrow_out);
        end
        do_op(8'hA5, 8'hA5, lat, bok);
        n_vec++;
        if ({bus.diff, bus.borrow_out, bus.overflow} !== {8'h00, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL equal_operands: got diff=%h bo=%b ov=%b want 00 0 0",
                     bus.diff, bus.borrow_out, bus.overflow);
        end
    endtask

    task automatic test_overflow();
        int lat;
        bit bok;
        do_op(8'h80, 8'h01, lat, bok);
        n_vec++;
        if ({bus.diff, bus.borrow_out, bus.overflow} !== {8'h7F, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL ovf_80_01: got diff=%h bo=%b ov=%b want 7f 0 1",
                     bus.diff, bus.borrow_out, bus.overflow);
        end
        do_op(8'h7F, 8'hFF, lat, bok);
        n_vec++;
        if ({bus.diff, bus.borrow_out, bus.overflow} !== {8'h80, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL ovf_7f_ff: got diff=%h bo=%b ov=%b want 80 1 1",
                     bus.diff, bus.borrow_out, bus.overflow);
        end
    endtask

    task automatic test_start_while_busy();
        int dones;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h33; bus.b = 8'h11;
        @(negedge clk);                               // cycle k
        bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
        @(negedge clk);                               // cycle k+1
        n_vec++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            n_err++; $display("FAIL busy_k1: got busy=%b done=%b want 1 0", bus.busy, bus.done);
        end
        n_vec++;
        if (bus.diff !== 8'h80) begin
            n_err++; $display("FAIL run_shows_prev: got diff=%h want 80", bus.diff);
        end
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00;
        @(negedge clk);                               // cycle k+2
        bus.start = 1'b0;
        n_vec++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            n_err++; $display("FAIL busy_k2: got busy=%b done=%b want 1 0", bus.busy, bus.done);
        end
        @(negedge clk);                               // cycle k+3
        n_vec++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            n_err++; $display("FAIL busy_k3: got busy=%b done=%b want 1 0", bus.busy, bus.done);
        end
        @(negedge clk);                               // cycle k+4
        n_vec++;
        if ({bus.busy, bus.done, bus.diff} !== {2'b01, 8'h22}) begin
            n_err++;
            $display("FAIL ignored_start_done: got busy=%b done=%b diff=%h want 0 1 22",
                     bus.busy, bus.done, bus.diff);
        end
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        n_vec++;
        if (dones !== 0) begin n_err++; $display("FAIL start_not_queued: got %0d extra dones want 0", dones); end
    endtask

    task automatic test_reset_mid_op();
        int dones;
        int lat;
        bit bok;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h5A; bus.b = 8'h23;
        @(negedge clk);                               // cycle k
        bus.start = 1'b0;
        @(negedge clk);                               // cycle k+1
        reset = 1'b1;
        @(negedge clk);                               // reset applied at edge k+2
        reset = 1'b0;
        n_vec++;
        if ({bus.busy, bus.done, bus.diff, bus.borrow_out, bus.overflow} !== 12'h000) begin
            n_err++;
            $display("FAIL mid_reset_state: got busy=%b done=%b diff=%h bo=%b ov=%b want all 0",
                     bus.busy, bus.done, bus.diff, bus.borrow_out, bus.overflow);
        end
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        n_vec++;
        if (dones !== 0) begin n_err++; $display("FAIL mid_reset_no_done: got %0d dones want 0", dones); end
        do_op(8'h09, 8'h04, lat, bok);
        n_vec++;
        if (lat !== 4 || bus.diff !== 8'h05) begin
            n_err++; $display("FAIL after_reset_op: got lat=%0d diff=%h want 4 05", lat, bus.diff);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit bok;
        int gap;
        do_op(8'h5A, 8'h23, lat, bok);
        n_vec++;
        if (lat !== 4 || bus.diff !== 8'h37) begin
            n_err++; $display("FAIL b2b_first: got lat=%0d diff=%h want 4 37", lat, bus.diff);
        end
        bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h02;  // sampled while in DONE
        gap = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin gap = i; break; end
        end
        n_vec++;
        if (gap !== 5) begin n_err++; $display("FAIL b2b_gap: got %0d want 5", gap); end
        n_vec++;
        if ({bus.diff, bus.borrow_out, bus.overflow} !== {8'hFF, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_second: got diff=%h bo=%b ov=%b want ff 1 0",
                     bus.diff, bus.borrow_out, bus.overflow);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
